// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_pkg: forwarding encodings, multiply FSM states and the shared forwarding-select helper
package hazard_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam int FWD_ADDR_W = 8;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;
  function automatic logic [1:0] fwd_sel(input logic [FWD_ADDR_W-1:0] src, input logic [FWD_ADDR_W-1:0] mem_rd,
                                         input logic mem_we, input logic [FWD_ADDR_W-1:0] wb_rd, input logic wb_we);
    return (src == '0) ? FWD_REG :
           (mem_we && src == mem_rd) ? FWD_MEM :
           (wb_we && src == wb_rd) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/hazard_forward_ctrl_mul_busy_tracker.sv
// mul_busy_tracker: tracks an in-flight multi-cycle multiply and the register it will write
module mul_busy_tracker
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  i_mul_start,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_mul_busy,
  output logic [REG_ADDR_W-1:0] o_mul_rd
);
  mul_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [REG_ADDR_W-1:0] r_mul_rd, w_mul_rd_nxt;
  // State, countdown and destination registers; reset abandons any multiply in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mul_rd <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mul_rd <= w_mul_rd_nxt;
    end
  end
  // Start only from IDLE (a start while busy is ignored); leave BUSY when the count reaches 1
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mul_rd_nxt = r_mul_rd;
    if (r_state == IDLE && i_mul_start) begin
      w_state_nxt  = BUSY;
      w_cnt_nxt    = CNT_W'(MUL_LAT - 1);
      w_mul_rd_nxt = i_ex_rd;
    end else if (r_state == BUSY) begin
      w_cnt_nxt   = r_cnt - CNT_W'(1);
      w_state_nxt = (r_cnt == CNT_W'(1)) ? IDLE : BUSY;
    end
  end
  assign o_mul_busy = (r_state == BUSY);
  assign o_mul_rd   = r_mul_rd;
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand forwarding plus load-use/multiply stall and flush (ID branch forwarding under BRANCH_ID_FWD_EN)
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_IsBranch,
  input  logic                  ID_IsMul,
  input  logic [REG_ADDR_W-1:0] EX_Rs,
  input  logic [REG_ADDR_W-1:0] EX_Rt,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_RegWrite,
  input  logic                  EX_MemRead,
  input  logic                  EX_MulStart,
  input  logic [REG_ADDR_W-1:0] MEM_Rd,
  input  logic [REG_ADDR_W-1:0] WB_Rd,
  input  logic                  MEM_RegWrite,
  input  logic                  WB_RegWrite,
  input  logic                  MEM_MemRead,
  output logic [1:0]            ForwardA_EX,
  output logic [1:0]            ForwardB_EX,
  output logic [1:0]            ForwardA_ID,
  output logic [1:0]            ForwardB_ID,
  output logic                  Stall,
  output logic                  Flush_EX,
  output logic                  MulBusy
);
  logic                  w_mul_busy;
  logic [REG_ADDR_W-1:0] w_mul_rd;
  logic [1:0]            w_fwd_a_id, w_fwd_b_id;
  logic                  w_id_uses_ex, w_id_uses_mul, w_load_use, w_mul_haz, w_br_haz, w_hazard;
  mul_busy_tracker #(.REG_ADDR_W(REG_ADDR_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) u_mul (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .i_mul_start(EX_MulStart),
    .i_ex_rd    (EX_Rd),
    .o_mul_busy (w_mul_busy),
    .o_mul_rd   (w_mul_rd)
  );
  assign w_id_uses_ex  = (EX_Rd != '0) && ((ID_UsesRs && ID_Rs == EX_Rd) || (ID_UsesRt && ID_Rt == EX_Rd));
  assign w_id_uses_mul = (w_mul_rd != '0) && ((ID_UsesRs && ID_Rs == w_mul_rd) || (ID_UsesRt && ID_Rt == w_mul_rd));
  assign w_load_use    = EX_MemRead && EX_RegWrite && w_id_uses_ex;
  assign w_mul_haz     = w_mul_busy && (w_id_uses_mul || ID_IsMul);
`ifdef BRANCH_ID_FWD_EN
  logic w_id_uses_mem;
  assign w_id_uses_mem = (MEM_Rd != '0) && ((ID_UsesRs && ID_Rs == MEM_Rd) || (ID_UsesRt && ID_Rt == MEM_Rd));
  assign w_fwd_a_id = fwd_sel(FWD_ADDR_W'(ID_Rs), FWD_ADDR_W'(MEM_Rd), MEM_RegWrite, FWD_ADDR_W'(WB_Rd), WB_RegWrite);
  assign w_fwd_b_id = fwd_sel(FWD_ADDR_W'(ID_Rt), FWD_ADDR_W'(MEM_Rd), MEM_RegWrite, FWD_ADDR_W'(WB_Rd), WB_RegWrite);
  assign w_br_haz   = ID_IsBranch && ((EX_RegWrite && w_id_uses_ex) || (MEM_MemRead && w_id_uses_mem));
`else
  logic w_unused;
  assign w_unused   = ^{ID_IsBranch, MEM_MemRead};
  assign w_fwd_a_id = FWD_REG;
  assign w_fwd_b_id = FWD_REG;
  assign w_br_haz   = 1'b0;
`endif
  assign w_hazard = w_load_use || w_mul_haz || w_br_haz;
  // Reset forces every output low immediately, independent of the clock
  always_comb begin
    ForwardA_EX = Rst_n ? fwd_sel(FWD_ADDR_W'(EX_Rs), FWD_ADDR_W'(MEM_Rd), MEM_RegWrite, FWD_ADDR_W'(WB_Rd), WB_RegWrite) : FWD_REG;
    ForwardB_EX = Rst_n ? fwd_sel(FWD_ADDR_W'(EX_Rt), FWD_ADDR_W'(MEM_Rd), MEM_RegWrite, FWD_ADDR_W'(WB_Rd), WB_RegWrite) : FWD_REG;
    ForwardA_ID = Rst_n ? w_fwd_a_id : FWD_REG;
    ForwardB_ID = Rst_n ? w_fwd_b_id : FWD_REG;
    Stall       = Rst_n && w_hazard;
    Flush_EX    = Rst_n && w_hazard;
    MulBusy     = Rst_n && w_mul_busy;
  end
endmodule
